// File: rtl/rng_fetcher.sv
// rng_fetcher: request side of the randomGenerator en_rng/done handshake
// with a show-ahead prefetch FIFO so consumers can pop every cycle.
//
// Ports:
//   clock       rising-edge clock
//   rst         asynchronous reset, active-high
//   fetch_en    1 = allow new requests to the generator
//   en_rng      one-cycle request pulse to the generator
//   rng_in      generator data, captured on the rising edge of done
//   done        generator completion flag
//   pop         consumer takes data_out this cycle
//   data_out    FIFO head, 0 when empty
//   valid       FIFO not empty
//   count       number of stored words
//   busy        a request is outstanding
//   timeout_cnt retries taken, saturating at 255
//
// Optional feature: define FETCHER_TIMEOUT_EN to re-issue a request
// after TIMEOUT cycles in WAIT without a done edge.
module rng_fetcher #(
   parameter int WIDTH   = 16,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 32
) (
   input  logic                    clock,
   input  logic                    rst,
   input  logic                    fetch_en,
   output logic                    en_rng,
   input  logic [WIDTH-1:0]        rng_in,
   input  logic                    done,
   input  logic                    pop,
   output logic [WIDTH-1:0]        data_out,
   output logic                    valid,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    busy,
   output logic [7:0]              timeout_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT
   } state_t;

   state_t state_q, state_d;

   logic             done_q;
   logic             done_rise;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en;
   logic             pop_ok;

`ifdef FETCHER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0] wait_q, wait_d;
   logic [7:0]    tcnt_q, tcnt_d;
`endif

   // Only a fresh edge counts; a level left high from an
   // earlier request must not be captured again.
   assign done_rise = done & ~done_q;

   assign pop_ok   = pop & (count_q != '0);
   assign valid    = (count_q != '0);
   assign count    = count_q;
   assign busy     = (state_q != IDLE);
   assign data_out = valid ? mem_q[rd_ptr_q] : '0;

`ifdef FETCHER_TIMEOUT_EN
   assign timeout_cnt = tcnt_q;
`else
   assign timeout_cnt = 8'd0;
`endif

   always_comb begin
      state_d = state_q;
      en_rng  = 1'b0;
      wr_en   = 1'b0;
`ifdef FETCHER_TIMEOUT_EN
      wait_d  = wait_q;
      tcnt_d  = tcnt_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (fetch_en && (count_q < FULL_C))
               state_d = REQ;
         end
         REQ: begin
            en_rng  = 1'b1;
            state_d = WAIT;
`ifdef FETCHER_TIMEOUT_EN
            wait_d  = '0;
`endif
         end
         WAIT: begin
            // A done edge wins over a simultaneous timeout.
            if (done_rise) begin
               wr_en   = 1'b1;
               state_d = IDLE;
            end
`ifdef FETCHER_TIMEOUT_EN
            else if (wait_q == TW'(TIMEOUT)) begin
               state_d = REQ;
               if (tcnt_q != 8'hFF)
                  tcnt_d = tcnt_q + 8'd1;
            end else begin
               wait_d = wait_q + TW'(1);
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Writes only come from WAIT, and a request is only issued
   // below full, so write+pop at full never overflows.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_en)
         wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)
         rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         done_q   <= 1'b0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
`ifdef FETCHER_TIMEOUT_EN
         wait_q   <= '0;
         tcnt_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         done_q   <= done;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
`ifdef FETCHER_TIMEOUT_EN
         wait_q   <= wait_d;
         tcnt_q   <= tcnt_d;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= rng_in;
   end

endmodule

// File: tb/tb_rng_fetcher.sv
// tb_rng_fetcher: directed and random stimulus for rng_fetcher,
// checked every cycle against a queue-based reference model.
module tb_rng_fetcher;

   localparam int WIDTH   = 16;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic        en_rng;
   logic [15:0] rng_in;
   logic        done;
   logic        pop;
   logic [15:0] data_out;
   logic        valid;
   logic [2:0]  count;
   logic        busy;
   logic [7:0]  timeout_cnt;

   always #5 clk = ~clk;

   rng_fetcher #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clock(clk),
      .rst(rst),
      .fetch_en(fetch_en),
      .en_rng(en_rng),
      .rng_in(rng_in),
      .done(done),
      .pop(pop),
      .data_out(data_out),
      .valid(valid),
      .count(count),
      .busy(busy),
      .timeout_cnt(timeout_cnt)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;
   int cyc    = 0;

   // generator: 0 normal, 1 done held high, 2 silent
   int          gen_mode = 0;
   int          gen_rise = -10;
   logic [15:0] gen_word = 16'h0;
   int          en_cyc[$];

   // reference model
   logic [15:0] m_q[$];
   bit          m_req;
   bit          m_out;
   bit          m_dprev;
   int          m_wc;
   int          m_tc;

   logic [15:0] popped[$];
   int          n6;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_gen();
      case (gen_mode)
         1:       done = 1'b1;
         2:       done = 1'b0;
         default: done = (cyc == gen_rise) || (cyc == gen_rise + 1);
      endcase
      rng_in = done ? gen_word : 16'($urandom);
   endtask

   task automatic check_outputs();
      chk("en_rng", en_rng, m_req);
      chk("busy", busy, m_out);
      chk("count", count, m_q.size());
      chk("valid", valid, m_q.size() != 0);
      chk("data_out", data_out, (m_q.size() != 0) ? m_q[0] : 16'h0);
      chk("timeout_cnt", timeout_cnt, m_tc);
   endtask

   task automatic model_step();
      int  sz;
      bit  rise;
      sz   = m_q.size();
      rise = done && !m_dprev;
      if (pop && sz > 0)
         void'(m_q.pop_front());
      if (m_req) begin
         m_req = 0;
         m_wc  = 1;
      end else if (m_out) begin
         if (rise) begin
            m_q.push_back(rng_in);
            m_out = 0;
         end else begin
`ifdef FETCHER_TIMEOUT_EN
            if (m_wc == TIMEOUT + 1) begin
               m_req = 1;
               if (m_tc < 255)
                  m_tc++;
            end else begin
               m_wc++;
            end
`endif
         end
      end else if (fetch_en && sz < DEPTH) begin
         m_req = 1;
         m_out = 1;
      end
      m_dprev = done;
   endtask

   // inputs for this cycle are already set; called at negedge
   task automatic tick();
      drive_gen();
      #1;
      check_outputs();
      if (en_rng === 1'b1) begin
         en_cyc.push_back(cyc);
         gen_word = gen_word + 16'h1111;
         gen_rise = cyc + 3;
      end
      model_step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++)
         tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drive_gen();
      #1;
      chk("rst_en_rng", en_rng, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", count, 0);
      chk("rst_valid", valid, 0);
      chk("rst_data", data_out, 0);
      chk("rst_tcnt", timeout_cnt, 0);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      rst = 1'b0;
      m_q.delete();
      m_req   = 0;
      m_out   = 0;
      m_dprev = 0;
      m_wc    = 0;
      m_tc    = 0;
   endtask

   task automatic wait_req(input int max);
      int n0;
      n0 = en_cyc.size();
      for (int i = 0; i < max; i++) begin
         if (en_cyc.size() > n0)
            break;
         tick();
      end
      chk("req_seen", en_cyc.size() > n0, 1);
   endtask

   initial begin
      rst      = 1'b1;
      fetch_en = 1'b0;
      pop      = 1'b0;
      done     = 1'b0;
      rng_in   = 16'h0;
      @(negedge clk);
      do_reset();

      // 1: fill from empty, requests stop at full
      fetch_en = 1'b1;
      en_cyc.delete();
      ticks(30);
      chk("t1_pulses", en_cyc.size(), 4);
      chk("t1_count", count, 4);
      chk("t1_head", data_out, 16'h1111);
      chk("t1_idle", en_rng, 0);

      // 2: drain in order while refetching
      pop = 1'b1;
      popped.delete();
      for (int i = 0; i < 6; i++) begin
         if (valid)
            popped.push_back(data_out);
         tick();
      end
      chk("t2_npop", popped.size() >= 4, 1);
      for (int i = 0; i < 4; i++) begin
         logic [15:0] w;
         w = 16'h1111 * 16'(i + 1);
         chk("t2_order", (popped.size() > i) ? popped[i] : 16'h0, w);
      end
      fetch_en = 1'b0;
      ticks(10);
      pop = 1'b0;
      ticks(3);
      chk("t2_valid", valid, 0);
      chk("t2_count", count, 0);

      // 3: done held high across the request
      gen_mode = 1;
      ticks(3);
      fetch_en = 1'b1;
      wait_req(10);
      fetch_en = 1'b0;
      ticks(8);
      chk("t3_nocap", count, 0);
      gen_mode = 2;
      tick();
      gen_mode = 1;
      tick();
      gen_mode = 0;
      tick();
      chk("t3_count", count, 1);
      chk("t3_word", data_out, gen_word);
      pop = 1'b1;
      ticks(2);
      pop = 1'b0;

      // 4: reset while waiting, late done ignored
      do_reset();
      fetch_en = 1'b1;
      wait_req(10);
      tick();
      fetch_en = 1'b0;
      do_reset();
      ticks(6);
      chk("t4_count", count, 0);
      chk("t4_busy", busy, 0);

      // 5: silent generator
      do_reset();
      gen_mode = 2;
      fetch_en = 1'b1;
      en_cyc.delete();
`ifdef FETCHER_TIMEOUT_EN
      ticks(3 * (TIMEOUT + 2) + 5);
      chk("t5_npulse", en_cyc.size(), 4);
      chk("t5_per1", en_cyc[1] - en_cyc[0], TIMEOUT + 2);
      chk("t5_per2", en_cyc[2] - en_cyc[1], TIMEOUT + 2);
      chk("t5_tcnt", timeout_cnt, 3);
      ticks(256 * (TIMEOUT + 2));
      chk("t5_sat", timeout_cnt, 255);
`else
      ticks(TIMEOUT + 10);
      chk("t5_npulse", en_cyc.size(), 1);
      chk("t5_busy", busy, 1);
`endif
      gen_mode = 0;
      do_reset();

      // 6: write and pop together at count 2, pointers wrap
      fetch_en = 1'b1;
      n6 = 0;
      for (int i = 0; i < 200 && n6 < 6; i++) begin
         pop = (m_q.size() == 2) && (cyc == gen_rise);
         if (pop) begin
            n6++;
            tick();
            chk("t6_count", count, 2);
         end else begin
            tick();
         end
      end
      pop = 1'b0;
      chk("t6_events", n6, 6);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         fetch_en = ($urandom_range(0, 3) != 0);
         pop      = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
